// File: rtl/svc_axi_sram_if_wr.sv
// AXI4 write-channel subordinate: turns one AW/W burst at a time into per-beat SRAM write
// commands and returns one B response. Optional error checking via SVC_AXI_SRAM_IF_WR_SLVERR_EN.
module svc_axi_sram_if_wr #(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    localparam int unsigned LSB = $clog2(AXI_DATA_WIDTH) - 3,
    localparam int unsigned SAW = AXI_ADDR_WIDTH - LSB
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    output logic                        sram_wr_cmd_valid,
    input  logic                        sram_wr_cmd_ready,
    output logic [SAW-1:0]              sram_wr_cmd_addr,
    output logic [AXI_ID_WIDTH-1:0]     sram_wr_cmd_meta,
    output logic                        sram_wr_cmd_last,
    output logic [AXI_DATA_WIDTH-1:0]   sram_wr_cmd_data,
    output logic [AXI_DATA_WIDTH/8-1:0] sram_wr_cmd_strb
);

    localparam int unsigned IW = AXI_ID_WIDTH;
    localparam int unsigned DW = AXI_DATA_WIDTH;
    localparam int unsigned SW = AXI_DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   id_q, id_d;
    logic [SAW-1:0]  waddr_q, waddr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;

    logic            awready_q, awready_d;
    logic            bvalid_q, bvalid_d;
    logic [IW-1:0]   bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [SAW-1:0]  cmd_addr_q, cmd_addr_d;
    logic [IW-1:0]   cmd_meta_q, cmd_meta_d;
    logic            cmd_last_q, cmd_last_d;
    logic [DW-1:0]   cmd_data_q, cmd_data_d;
    logic [SW-1:0]   cmd_strb_q, cmd_strb_d;

    logic aw_hs, w_hs, cmd_hs, b_hs, last_beat, wready_c;
    logic aw_err_c, wlast_err_c;

`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
    assign aw_err_c    = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'(LSB));
    assign wlast_err_c = (s_axi_wlast != last_beat);
`else
    logic unused_ok;
    assign unused_ok   = ^{s_axi_awburst, s_axi_awsize, s_axi_wlast};
    assign aw_err_c    = 1'b0;
    assign wlast_err_c = 1'b0;
`endif

    // wready follows the command slot combinationally so a draining slot refills in the same cycle
    assign wready_c  = (state_q == BURST) && !done_q && (!cmd_valid_q || sram_wr_cmd_ready);
    assign aw_hs     = s_axi_awvalid && awready_q;
    assign w_hs      = s_axi_wvalid && wready_c;
    assign cmd_hs    = cmd_valid_q && sram_wr_cmd_ready;
    assign b_hs      = bvalid_q && s_axi_bready;
    assign last_beat = (beat_q == len_q);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        waddr_d     = waddr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        done_d      = done_q;
        drop_d      = drop_q;
        err_d       = err_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        cmd_valid_d = cmd_valid_q && !sram_wr_cmd_ready;
        cmd_addr_d  = cmd_addr_q;
        cmd_meta_d  = cmd_meta_q;
        cmd_last_d  = cmd_last_q;
        cmd_data_d  = cmd_data_q;
        cmd_strb_d  = cmd_strb_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = BURST;
                    id_d    = s_axi_awid;
                    waddr_d = s_axi_awaddr[AXI_ADDR_WIDTH-1:LSB];
                    len_d   = s_axi_awlen;
                    beat_d  = 8'd0;
                    done_d  = 1'b0;
                    drop_d  = aw_err_c;
                    err_d   = aw_err_c;
                end
            end
            BURST: begin
                if (w_hs) begin
                    beat_d  = beat_q + 8'd1;
                    waddr_d = waddr_q + SAW'(1);
                    if (last_beat)   done_d = 1'b1;
                    if (wlast_err_c) err_d  = 1'b1;
                    if (!drop_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = waddr_q;
                        cmd_meta_d  = id_q;
                        cmd_last_d  = last_beat;
                        cmd_data_d  = s_axi_wdata;
                        cmd_strb_d  = s_axi_wstrb;
                    end else if (last_beat) begin
                        state_d = RESP;
                    end
                end
                // Only the final command can be pending once all beats are in
                if (done_q && cmd_hs) state_d = RESP;
            end
            RESP: begin
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        bvalid_d  = (state_d == RESP);
        if ((state_q != RESP) && (state_d == RESP)) begin
            bid_d   = id_q;
            bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            waddr_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_meta_q  <= '0;
            cmd_last_q  <= 1'b0;
            cmd_data_q  <= '0;
            cmd_strb_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            waddr_q     <= waddr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_meta_q  <= cmd_meta_d;
            cmd_last_q  <= cmd_last_d;
            cmd_data_q  <= cmd_data_d;
            cmd_strb_q  <= cmd_strb_d;
        end
    end

    assign s_axi_awready     = awready_q;
    assign s_axi_wready      = wready_c;
    assign s_axi_bvalid      = bvalid_q;
    assign s_axi_bid         = bid_q;
    assign s_axi_bresp       = bresp_q;
    assign sram_wr_cmd_valid = cmd_valid_q;
    assign sram_wr_cmd_addr  = cmd_addr_q;
    assign sram_wr_cmd_meta  = cmd_meta_q;
    assign sram_wr_cmd_last  = cmd_last_q;
    assign sram_wr_cmd_data  = cmd_data_q;
    assign sram_wr_cmd_strb  = cmd_strb_q;

endmodule

// File: tb/tb_svc_axi_sram_if_wr.sv
// Scoreboard bench for svc_axi_sram_if_wr: the driver pushes expected SRAM commands and
// B responses per burst, a negedge monitor pops and compares on every handshake.
module tb_svc_axi_sram_if_wr;

    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 16;
    localparam int unsigned IW  = 4;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LSB = $clog2(DW) - 3;
    localparam int unsigned SAW = AW - LSB;
    localparam int unsigned CW  = SAW + IW + 1 + DW + SW;

    typedef logic [CW-1:0]   cmd_t;
    typedef logic [IW+1:0]   b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_axi_awvalid = 1'b0;
    logic s_axi_awready;
    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [2:0]    s_axi_awsize = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic s_axi_wvalid = 1'b0;
    logic s_axi_wready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic s_axi_wlast = 1'b0;
    logic s_axi_bvalid;
    logic s_axi_bready = 1'b0;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic sram_wr_cmd_valid;
    logic sram_wr_cmd_ready = 1'b0;
    logic [SAW-1:0] sram_wr_cmd_addr;
    logic [IW-1:0]  sram_wr_cmd_meta;
    logic           sram_wr_cmd_last;
    logic [DW-1:0]  sram_wr_cmd_data;
    logic [SW-1:0]  sram_wr_cmd_strb;

    svc_axi_sram_if_wr #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .sram_wr_cmd_valid(sram_wr_cmd_valid), .sram_wr_cmd_ready(sram_wr_cmd_ready),
        .sram_wr_cmd_addr(sram_wr_cmd_addr), .sram_wr_cmd_meta(sram_wr_cmd_meta),
        .sram_wr_cmd_last(sram_wr_cmd_last), .sram_wr_cmd_data(sram_wr_cmd_data),
        .sram_wr_cmd_strb(sram_wr_cmd_strb)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   n_b = 0;
    cmd_t exp_cmd[$];
    b_t   exp_b[$];
    bit   rdy_force = 1'b1, rdy_val = 1'b1;
    bit   b_force = 1'b1, b_val = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready generators for the SRAM side and the B channel
    initial forever begin
        @(posedge clk);
        #2;
        sram_wr_cmd_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        s_axi_bready      = b_force ? b_val : ($urandom_range(0, 2) != 0);
    end

    // Monitor: handshakes seen here complete on the following posedge
    initial begin
        bit   exp_b_nxt = 1'b0;
        bit   exp_aw_nxt = 1'b0;
        cmd_t act, exp;
        b_t   bact, bexp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_b_nxt  = 1'b0;
                exp_aw_nxt = 1'b0;
            end else begin
                if (exp_b_nxt)  chk("bvalid_after_last_cmd", 64'(s_axi_bvalid), 64'd1);
                if (exp_aw_nxt) chk("awready_after_b", 64'(s_axi_awready), 64'd1);
                exp_b_nxt  = 1'b0;
                exp_aw_nxt = 1'b0;
                if (sram_wr_cmd_valid && sram_wr_cmd_ready) begin
                    act = {sram_wr_cmd_addr, sram_wr_cmd_meta, sram_wr_cmd_last,
                           sram_wr_cmd_data, sram_wr_cmd_strb};
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cmd_unexpected: got cmd %0h expected none", act);
                    end else begin
                        exp = exp_cmd.pop_front();
                        chk("sram_cmd", 64'(act), 64'(exp));
                    end
                    if (sram_wr_cmd_last) exp_b_nxt = 1'b1;
                end
                if (s_axi_bvalid && s_axi_bready) begin
                    bact = {s_axi_bid, s_axi_bresp};
                    n_b++;
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got b %0h expected none", bact);
                    end else begin
                        bexp = exp_b.pop_front();
                        chk("b_resp", 64'(bact), 64'(bexp));
                    end
                    exp_aw_nxt = 1'b1;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(s_axi_awready), 64'd0);
        chk({tag, "_wready"},  64'(s_axi_wready), 64'd0);
        chk({tag, "_bvalid"},  64'(s_axi_bvalid), 64'd0);
        chk({tag, "_bid"},     64'(s_axi_bid), 64'd0);
        chk({tag, "_bresp"},   64'(s_axi_bresp), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(sram_wr_cmd_valid), 64'd0);
        chk({tag, "_cmd_fields"}, 64'({sram_wr_cmd_addr, sram_wr_cmd_meta, sram_wr_cmd_last,
                                        sram_wr_cmd_data, sram_wr_cmd_strb}), 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("awready_before_first_edge", 64'(s_axi_awready), 64'd0);
        @(negedge clk);
        chk("awready_after_release", 64'(s_axi_awready), 64'd1);
    endtask

    // Drives one burst and pushes its expected commands and response into the scoreboard
    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input bit fixed,
                            input logic [DW-1:0] d0, input bit gaps, input bit bad_last,
                            input int abort_after, output int w_cycles);
        logic [DW-1:0] d[$];
        logic [SW-1:0] s[$];
        bit flagged, mism, hs;
        int cyc;
        for (int i = 0; i <= len; i++) begin
            d.push_back(fixed ? DW'(d0 + DW'(i)) : DW'($urandom));
            s.push_back(fixed ? {SW{1'b1}} : SW'($urandom));
        end
`ifdef SVC_AXI_SRAM_IF_WR_SLVERR_EN
        flagged = (burst != 2'b01) || (size != 3'(LSB));
        mism    = bad_last;
`else
        flagged = 1'b0;
        mism    = 1'b0;
`endif
        if (!flagged)
            for (int i = 0; i <= len; i++)
                exp_cmd.push_back({SAW'((addr >> LSB) + i), id, (i == len), d[i], s[i]});
        exp_b.push_back({id, (flagged || mism) ? 2'b10 : 2'b00});

        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awburst = burst;
        s_axi_awsize  = size;
        cyc = 0;
        do begin
            @(negedge clk);
            hs = s_axi_awready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!hs && cyc < 1000);
        chk("aw_handshake", 64'(hs), 64'd1);
        s_axi_awvalid = 1'b0;

        w_cycles = 0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_axi_wvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = d[i];
            s_axi_wstrb  = s[i];
            s_axi_wlast  = (i == len) ^ (bad_last && (i == len));
            cyc = 0;
            do begin
                @(negedge clk);
                hs = s_axi_wready;
                @(posedge clk);
                #1;
                cyc++;
                w_cycles++;
            end while (!hs && cyc < 1000);
            chk("w_handshake", 64'(hs), 64'd1);
            if (abort_after == i + 1) begin
                s_axi_wvalid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_cmd_valid", 64'(sram_wr_cmd_valid), 64'd0);
                chk("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
                chk("abort_wready", 64'(s_axi_wready), 64'd0);
                exp_cmd.delete();
                exp_b.delete();
                break;
            end
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int cyc = 0;
        while ((exp_cmd.size() != 0 || exp_b.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk(nm, 64'(exp_cmd.size() + exp_b.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, nb0, len;
        logic [1:0] bt;
        logic [2:0] sz;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        release_reset();

        // Single beat
        do_burst(4'hB, 20'h0A000, 0, 2'b01, 3'(LSB), 1'b1, 16'h1234, 1'b0, 1'b0, -1, wc);
        drain("single_drain");

        // SRAM backpressure: command held stable, W blocked
        rdy_val = 1'b0;
        do_burst(4'h3, 20'h00100, 0, 2'b01, 3'(LSB), 1'b1, 16'hBEEF, 1'b0, 1'b0, -1, wc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_cmd_valid", 64'(sram_wr_cmd_valid), 64'd1);
            chk("bp_cmd_fields", 64'({sram_wr_cmd_addr, sram_wr_cmd_meta, sram_wr_cmd_last,
                                      sram_wr_cmd_data, sram_wr_cmd_strb}),
                64'({SAW'(20'h00080), 4'h3, 1'b1, 16'hBEEF, 2'b11}));
            chk("bp_wready", 64'(s_axi_wready), 64'd0);
        end
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
        drain("bp_drain");

        // Address wrap from the top word, full throughput, one B
        nb0 = n_b;
        do_burst(4'h5, 20'hFFFFE, 3, 2'b01, 3'(LSB), 1'b1, 16'h0100, 1'b0, 1'b0, -1, wc);
        chk("wrap_w_cycles", 64'(wc), 64'd4);
        drain("wrap_drain");
        chk("wrap_b_count", 64'(n_b - nb0), 64'd1);

        // Reset in the middle of a burst, then a normal burst
        nb0 = n_b;
        do_burst(4'h7, 20'h01000, 7, 2'b01, 3'(LSB), 1'b0, '0, 1'b0, 1'b0, 2, wc);
        repeat (2) @(posedge clk);
        chk("abort_no_b", 64'(n_b - nb0), 64'd0);
        release_reset();
        do_burst(4'h8, 20'h01234, 2, 2'b01, 3'(LSB), 1'b0, '0, 1'b0, 1'b0, -1, wc);
        drain("post_reset_drain");

        // Non-INCR burst type
        do_burst(4'h9, 20'h02000, 1, 2'b00, 3'(LSB), 1'b0, '0, 1'b0, 1'b0, -1, wc);
        drain("fixed_burst_drain");

        // Randomized traffic
        rdy_force = 1'b0;
        b_force   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(32, 255))
                                               : int'($urandom_range(0, 15));
            bt  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
            sz  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(LSB);
            do_burst(IW'($urandom), ($urandom_range(0, 3) == 0) ? AW'(20'hFFFF0 | AW'($urandom_range(0, 15)))
                                                                 : AW'($urandom),
                     len, bt, sz, 1'b0, '0, 1'b1, ($urandom_range(0, 7) == 0), -1, wc);
        end
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
